osc_phase_acc: RTL and testbench

OSC_PHASE_ACC -- requirements
Module: osc_phase_acc

---
 rtl/osc_pkg.sv | 17 +
 rtl/osc_delay_line.sv | 28 ++
 rtl/osc_phase_acc.sv | 117 +++++++++++
 tb/tb_osc_phase_acc.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/osc_pkg.sv
// Shared definitions for the oscillator phase accumulator.
//   OSC_VOICES  : default number of time-multiplexed voices
//   OSC_PHASE_W : default phase accumulator width
//   OSC_ADDR_W  : default sine table address width
//   OSC_LUT_LAT : default downstream sine lookup latency (clocks)
//   osc_state_e : frame sequencer states
package osc_pkg;
  localparam int OSC_VOICES  = 8;
  localparam int OSC_PHASE_W = 32;
  localparam int OSC_ADDR_W  = 11;
  localparam int OSC_LUT_LAT = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } osc_state_e;
endpackage

// File: rtl/osc_delay_line.sv
// Fixed-depth shift register that carries the addr-side sideband
// (valid, voice, last) forward so it lines up with the sine value.
//   clk   : clock
//   reset : synchronous active-high; clears every stage
//   din   : word entering the line
//   dout  : word DEPTH clocks later
module osc_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [DEPTH-1:0][WIDTH-1:0] pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];
endmodule

// File: rtl/osc_phase_acc.sv
// Time-multiplexed phase accumulator for a bank of oscillator voices.
// Each sample_tick starts a frame that visits voices 0..VOICES-1, one per
// clock, emitting the top ADDR_W bits of each voice's pre-update phase as a
// sine table address, then advancing the phase by that voice's increment.
//   clk, reset              : clock, synchronous active-high reset
//   sample_tick             : starts a frame (ignored + overrun if busy)
//   inc_wr/inc_voice/inc_data : frequency increment write
//   sync_en/sync_voice      : hard-sync phase reset
//   addr/addr_valid/addr_voice : sine table lookup request
//   out_valid/out_voice     : request sideband delayed by LUT_LAT
//   frame_done              : pulse with the last out_valid of a frame
//   overrun                 : sticky, tick seen while a frame was running
module osc_phase_acc
  import osc_pkg::*;
#(
  parameter int VOICES  = OSC_VOICES,
  parameter int PHASE_W = OSC_PHASE_W,
  parameter int ADDR_W  = OSC_ADDR_W,
  parameter int LUT_LAT = OSC_LUT_LAT,
  localparam int VW     = $clog2(VOICES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_tick,
  input  logic               inc_wr,
  input  logic [VW-1:0]      inc_voice,
  input  logic [PHASE_W-1:0] inc_data,
  input  logic               sync_en,
  input  logic [VW-1:0]      sync_voice,
  output logic [ADDR_W-1:0]  addr,
  output logic               addr_valid,
  output logic [VW-1:0]      addr_voice,
  output logic               out_valid,
  output logic [VW-1:0]      out_voice,
  output logic               frame_done,
  output logic               overrun
);
  localparam logic [VW-1:0] VLAST = VW'(VOICES - 1);
  localparam int            DLW   = VW + 2;

  osc_state_e         state;
  logic [VW-1:0]      vcnt;
  logic               last;
  logic [PHASE_W-1:0] phase [VOICES];
  logic [PHASE_W-1:0] inc   [VOICES];
  logic               sync_hit;
  logic [DLW-1:0]     dl_out;

  // Sync landing on the voice being processed this cycle.
  assign sync_hit = sync_en && (sync_voice == vcnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      vcnt       <= '0;
      last       <= 1'b0;
      addr       <= '0;
      addr_valid <= 1'b0;
      addr_voice <= '0;
      overrun    <= 1'b0;
      for (int i = 0; i < VOICES; i++) begin
        phase[i] <= '0;
        inc[i]   <= '0;
      end
    end else begin
      addr_valid <= 1'b0;
      last       <= 1'b0;
      if (inc_wr)  inc[inc_voice]    <= inc_data;
      // Non-current voice sync; the current-voice case below overrides it.
      if (sync_en) phase[sync_voice] <= '0;
      case (state)
        ST_IDLE: begin
          if (sample_tick) begin
            state <= ST_RUN;
            vcnt  <= '0;
          end
        end
        ST_RUN: begin
          if (sample_tick) overrun <= 1'b1;
          addr_valid <= 1'b1;
          addr_voice <= vcnt;
          last       <= (vcnt == VLAST);
          // Sync restarts the voice at phase 0 this very cycle, so the
          // stored value is already one increment on (old increment).
          if (sync_hit) begin
            addr        <= '0;
            phase[vcnt] <= inc[vcnt];
          end else begin
            addr        <= phase[vcnt][PHASE_W-1 -: ADDR_W];
            phase[vcnt] <= phase[vcnt] + inc[vcnt];
          end
          if (vcnt == VLAST) begin
            state <= ST_IDLE;
            vcnt  <= '0;
          end else begin
            vcnt <= vcnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  osc_delay_line #(
    .WIDTH (DLW),
    .DEPTH (LUT_LAT)
  ) u_dly (
    .clk   (clk),
    .reset (reset),
    .din   ({addr_valid, addr_voice, last}),
    .dout  (dl_out)
  );

  assign out_valid  = dl_out[DLW-1];
  assign out_voice  = dl_out[DLW-2:1];
  assign frame_done = dl_out[DLW-1] & dl_out[0];
endmodule

// File: tb/tb_osc_phase_acc.sv
module tb_osc_phase_acc;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic        inc_wr = 1'b0;
  logic [2:0]  inc_voice = '0;
  logic [31:0] inc_data = '0;
  logic        sync_en = 1'b0;
  logic [2:0]  sync_voice = '0;
  logic [10:0] addr;
  logic        addr_valid;
  logic [2:0]  addr_voice;
  logic        out_valid;
  logic [2:0]  out_voice;
  logic        frame_done;
  logic        overrun;

  osc_phase_acc dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .inc_wr(inc_wr), .inc_voice(inc_voice), .inc_data(inc_data),
    .sync_en(sync_en), .sync_voice(sync_voice),
    .addr(addr), .addr_valid(addr_valid), .addr_voice(addr_voice),
    .out_valid(out_valid), .out_voice(out_voice),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int voice;
    int val;
  } ent_t;

  ent_t aq[$];
  ent_t oq[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   exp_addr [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: pops an expected entry every time the DUT presents a request
  // or an aligned output, and compares cycle, voice and payload.
  always @(negedge clk) begin
    ent_t e;
    if (addr_valid) begin
      if (aq.size() == 0) begin
        chk("addr_unexpected_voice", addr_voice, 99);
      end else begin
        e = aq.pop_front();
        chk("addr_cycle", cyc, e.cyc);
        chk("addr_voice", addr_voice, e.voice);
        chk("addr", addr, e.val);
      end
    end
    if (out_valid) begin
      if (oq.size() == 0) begin
        chk("out_unexpected_voice", out_voice, 99);
      end else begin
        e = oq.pop_front();
        chk("out_cycle", cyc, e.cyc);
        chk("out_voice", out_voice, e.voice);
        chk("frame_done", frame_done, e.val);
      end
    end else if (frame_done) begin
      chk("frame_done_without_out_valid", frame_done, 0);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_exp(input int a0, input int a1, input int a2, input int a3);
    for (int k = 0; k < 8; k++) exp_addr[k] = 0;
    exp_addr[0] = a0; exp_addr[1] = a1; exp_addr[2] = a2; exp_addr[3] = a3;
  endtask

  // Raises sample_tick for the current cycle T and queues the expected
  // requests (T+2+k) and aligned outputs (T+5+k). Returns at T+1.
  task automatic do_tick(input int na, input int no);
    int t0;
    t0 = cyc;
    sample_tick = 1'b1;
    for (int k = 0; k < na; k++) aq.push_back(ent_t'{t0 + 2 + k, k, exp_addr[k]});
    for (int k = 0; k < no; k++) oq.push_back(ent_t'{t0 + 5 + k, k, (k == 7) ? 1 : 0});
    step(1);
    sample_tick = 1'b0;
  endtask

  task automatic wr_inc(input int v, input logic [31:0] d);
    inc_wr = 1'b1; inc_voice = 3'(v); inc_data = d;
    step(1);
    inc_wr = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr_valid"}, addr_valid, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_addr_voice"}, addr_voice, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_voice"}, out_voice, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    chk_all_zero("reset");
    reset = 1'b0;
    step(2);

    // Voice 0 advances by one table step per frame.
    wr_inc(0, 32'h0020_0000);
    for (int i = 0; i < 4; i++) begin
      set_exp(i, 0, 0, 0);
      do_tick(8, 8);
      step(19);
    end
    chk("overrun_clean", overrun, 0);
    chk("addr_voice_hold", addr_voice, 7);

    // Park voice 0: zero increment and sync in the same idle cycle.
    inc_wr = 1'b1; inc_voice = 3'd0; inc_data = '0;
    sync_en = 1'b1; sync_voice = 3'd0;
    step(1);
    inc_wr = 1'b0; sync_en = 1'b0;

    // Preload voice 3 to 0xFFE00000, then observe the wrap.
    wr_inc(3, 32'hFFE0_0000);
    set_exp(0, 0, 0, 0);
    do_tick(8, 8);
    step(19);
    wr_inc(3, 32'h0020_0000);
    set_exp(0, 0, 0, 11'h7FF);
    do_tick(8, 8);
    step(19);
    set_exp(0, 0, 0, 0);
    do_tick(8, 8);
    step(19);

    // Tick during a running frame: flagged, no extra frame.
    set_exp(0, 0, 0, 1);
    do_tick(8, 8);
    step(3);
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    step(15);
    chk("overrun_set", overrun, 1);

    // Hard sync on voice 2 while it is processed, with a same-cycle
    // increment write that must only affect later frames.
    wr_inc(2, 32'h0040_0000);
    set_exp(0, 0, 0, 2);
    do_tick(8, 8);
    step(19);
    set_exp(0, 0, 0, 3);
    do_tick(8, 8);
    step(2);
    sync_en = 1'b1; sync_voice = 3'd2;
    inc_wr = 1'b1; inc_voice = 3'd2; inc_data = 32'h0060_0000;
    step(1);
    sync_en = 1'b0; inc_wr = 1'b0;
    step(16);
    set_exp(0, 0, 2, 4);
    do_tick(8, 8);
    step(19);
    chk("overrun_sticky", overrun, 1);

    // Reset at T+5 aborts the frame: voices 0..3 requested, voice 0 output.
    set_exp(0, 0, 5, 5);
    do_tick(4, 1);
    step(4);
    reset = 1'b1;
    step(1);
    chk_all_zero("midreset");
    reset = 1'b0;
    step(20);
    chk("midreset_addr_q_empty", aq.size(), 0);
    chk("midreset_out_q_empty", oq.size(), 0);

    // Fresh start after reset: phases and increments are zero.
    wr_inc(0, 32'h0020_0000);
    set_exp(0, 0, 0, 0);
    do_tick(8, 8);
    step(19);
    set_exp(1, 0, 0, 0);
    do_tick(8, 8);
    step(25);

    chk("final_addr_q_empty", aq.size(), 0);
    chk("final_out_q_empty", oq.size(), 0);
    chk("final_overrun", overrun, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
